arcade_input_mapper: RTL and testbench

//  Parametrised keyboard + joystick to arcade-control mapper; successor to the per-core inline ps2_key decoder.

---
 rtl/arcade_input_pkg.sv | 54 +++++
 rtl/arcade_input_mapper_if.sv | 33 +++
 rtl/arcade_coin_stretch.sv | 61 ++++++
 rtl/arcade_input_mapper.sv | 214 +++++++++++++++++++++
 tb/tb_arcade_input_mapper.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input mapper: PS/2 scancodes,
// joystick bit layout, per-player key state and coin stretcher states.
package arcade_input_pkg;

  localparam int KEY_PLAYERS = 2;
  localparam int KEY_BUTTONS = 4;

  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_LCTRL  = 8'h14;
  localparam logic [7:0] SC_LALT   = 8'h11;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_1      = 8'h16;
  localparam logic [7:0] SC_5      = 8'h2E;
  localparam logic [7:0] SC_F1     = 8'h05;

  localparam logic [7:0] SC_R      = 8'h2D;
  localparam logic [7:0] SC_F      = 8'h2B;
  localparam logic [7:0] SC_D      = 8'h23;
  localparam logic [7:0] SC_G      = 8'h34;
  localparam logic [7:0] SC_A      = 8'h1C;
  localparam logic [7:0] SC_S      = 8'h1B;
  localparam logic [7:0] SC_Q      = 8'h15;
  localparam logic [7:0] SC_W      = 8'h1D;
  localparam logic [7:0] SC_2      = 8'h1E;
  localparam logic [7:0] SC_6      = 8'h36;
  localparam logic [7:0] SC_F2     = 8'h06;

  localparam int JOY_R   = 0;
  localparam int JOY_L   = 1;
  localparam int JOY_D   = 2;
  localparam int JOY_U   = 3;
  localparam int JOY_BTN = 4;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    WAIT
  } coin_state_t;

  typedef struct packed {
    logic                   up;
    logic                   down;
    logic                   left;
    logic                   right;
    logic                   start;
    logic                   coin;
    logic [KEY_BUTTONS-1:0] btn;
  } key_t;

endpackage

// File: rtl/arcade_input_mapper_if.sv
// Host <-> mapper bundle: ps2_key, joysticks and config from the host,
// cleaned per-player controls back. master = host side, slave = mapper.
interface arcade_input_mapper_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_BUTTONS = 4
);
  logic [10:0]                        ps2_key;
  logic [16*NUM_PLAYERS-1:0]          joystick;
  logic                               rotate;
  logic                               merge_joy;
  logic [NUM_BUTTONS-1:0]             autofire_mask;
  logic [NUM_PLAYERS-1:0]             p_up;
  logic [NUM_PLAYERS-1:0]             p_down;
  logic [NUM_PLAYERS-1:0]             p_left;
  logic [NUM_PLAYERS-1:0]             p_right;
  logic [NUM_PLAYERS*NUM_BUTTONS-1:0] p_btn;
  logic [NUM_PLAYERS-1:0]             p_start;
  logic [NUM_PLAYERS-1:0]             p_coin;

  modport master (
    output ps2_key, joystick, rotate,
    output merge_joy, autofire_mask,
    input  p_up, p_down, p_left, p_right,
    input  p_btn, p_start, p_coin
  );

  modport slave (
    input  ps2_key, joystick, rotate,
    input  merge_joy, autofire_mask,
    output p_up, p_down, p_left, p_right,
    output p_btn, p_start, p_coin
  );
endinterface

// File: rtl/arcade_coin_stretch.sv
// Coin pulse stretcher: output high for max(raw width, COIN_MIN_CYCLES).
// Ports: clk_sys, reset_n (async low), raw coin in, stretched coin out.
module arcade_coin_stretch
  import arcade_input_pkg::*;
#(
  parameter int COIN_MIN_CYCLES = 120000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic raw,
  output logic coin
);

  localparam int CW = $clog2(COIN_MIN_CYCLES + 1);

  coin_state_t   state_q;
  coin_state_t   state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Raw high in IDLE counts as a rise: after WAIT the raw line is
  // already low, and a coin held through reset must start a new pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (raw) begin
          state_d = HOLD;
          cnt_d   = CW'(COIN_MIN_CYCLES - 1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = raw ? WAIT : IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WAIT: begin
        if (!raw) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    coin = (state_q != IDLE);
  end

endmodule

// File: rtl/arcade_input_mapper.sv
// Keyboard + joystick to arcade control mapper (N players).
// Ports: clk_sys, reset_n, io (slave). Option: ARCADE_INPUT_AUTOFIRE_EN.
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int NUM_BUTTONS     = 4,
  parameter int COIN_MIN_CYCLES = 120000,
  parameter int AUTOFIRE_DIV    = 200000
) (
  input logic clk_sys,
  input logic reset_n,
  arcade_input_mapper_if.slave io
);

  localparam int NP        = NUM_PLAYERS;
  localparam int NB        = NUM_BUTTONS;
  localparam int JOY_START = JOY_BTN + NB;
  localparam int JOY_COIN  = JOY_BTN + NB + 1;

  key_t key_q [KEY_PLAYERS];
  key_t key_d [KEY_PLAYERS];
  logic old_toggle;
  logic primed;
  logic pr;
  logic key_evt;

  assign pr      = io.ps2_key[9];
  // First cycle after reset only samples the toggle, so a stale
  // ps2_key left over from before reset is never decoded.
  assign key_evt = primed && (io.ps2_key[10] != old_toggle);

  always_comb begin
    key_d = key_q;
    unique case (io.ps2_key[7:0])
      SC_UP:     key_d[0].up     = pr;
      SC_DOWN:   key_d[0].down   = pr;
      SC_LEFT:   key_d[0].left   = pr;
      SC_RIGHT:  key_d[0].right  = pr;
      SC_SPACE:  key_d[0].btn[0] = pr;
      SC_LCTRL:  key_d[0].btn[1] = pr;
      SC_LALT:   key_d[0].btn[2] = pr;
      SC_LSHIFT: key_d[0].btn[3] = pr;
      SC_1:      key_d[0].start  = pr;
      SC_F1:     key_d[0].start  = pr;
      SC_5:      key_d[0].coin   = pr;
      SC_R:      key_d[1].up     = pr;
      SC_F:      key_d[1].down   = pr;
      SC_D:      key_d[1].left   = pr;
      SC_G:      key_d[1].right  = pr;
      SC_A:      key_d[1].btn[0] = pr;
      SC_S:      key_d[1].btn[1] = pr;
      SC_Q:      key_d[1].btn[2] = pr;
      SC_W:      key_d[1].btn[3] = pr;
      SC_2:      key_d[1].start  = pr;
      SC_F2:     key_d[1].start  = pr;
      SC_6:      key_d[1].coin   = pr;
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      old_toggle <= 1'b0;
      primed     <= 1'b0;
      for (int p = 0; p < KEY_PLAYERS; p++) begin
        key_q[p] <= '0;
      end
    end else begin
      old_toggle <= io.ps2_key[10];
      primed     <= 1'b1;
      if (key_evt) key_q <= key_d;
    end
  end

  logic [15:0] joy_or;

  always_comb begin
    joy_or = '0;
    for (int p = 0; p < NP; p++) begin
      joy_or |= io.joystick[16*p +: 16];
    end
  end

  logic [NP-1:0]    up_c;
  logic [NP-1:0]    dn_c;
  logic [NP-1:0]    lf_c;
  logic [NP-1:0]    rt_c;
  logic [NP-1:0]    st_c;
  logic [NP-1:0]    coin_raw;
  logic [NP-1:0]    coin_w;
  logic [NP*NB-1:0] btn_c;
  logic [NP*NB-1:0] btn_o;

  for (genvar p = 0; p < NP; p++) begin : g_pl
    key_t        k;
    logic [15:0] j;
    logic        u, d, l, r;
    logic        ru, rd, rl, rr;

    if (p < KEY_PLAYERS) begin : g_key
      assign k = key_q[p];
    end else begin : g_nokey
      assign k = '0;
    end

    assign j = (p == 0 && io.merge_joy)
             ? joy_or : io.joystick[16*p +: 16];

    assign u = k.up    | j[JOY_U];
    assign d = k.down  | j[JOY_D];
    assign l = k.left  | j[JOY_L];
    assign r = k.right | j[JOY_R];

    assign ru = io.rotate ? l : u;
    assign rd = io.rotate ? r : d;
    assign rl = io.rotate ? d : l;
    assign rr = io.rotate ? u : r;

    // Opposite directions cancel instead of letting one win.
    assign up_c[p] = ru & ~rd;
    assign dn_c[p] = rd & ~ru;
    assign lf_c[p] = rl & ~rr;
    assign rt_c[p] = rr & ~rl;

    for (genvar b = 0; b < NB; b++) begin : g_b
      if (b < KEY_BUTTONS) begin : g_kb
        assign btn_c[NB*p+b] = k.btn[b] | j[JOY_BTN+b];
      end else begin : g_jb
        assign btn_c[NB*p+b] = j[JOY_BTN+b];
      end
    end

    assign st_c[p]     = k.start | j[JOY_START];
    assign coin_raw[p] = k.coin  | j[JOY_COIN];

    arcade_coin_stretch #(
      .COIN_MIN_CYCLES(COIN_MIN_CYCLES)
    ) u_coin (
      .clk_sys(clk_sys),
      .reset_n(reset_n),
      .raw    (coin_raw[p]),
      .coin   (coin_w[p])
    );
  end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
  localparam int AW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;

  logic [AW-1:0] af_cnt;
  logic          af_phase;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      af_cnt   <= '0;
      af_phase <= 1'b0;
    end else if (af_cnt == AW'(AUTOFIRE_DIV - 1)) begin
      af_cnt   <= '0;
      af_phase <= ~af_phase;
    end else begin
      af_cnt   <= af_cnt + AW'(1);
    end
  end

  always_comb begin
    btn_o = btn_c;
    for (int p = 0; p < NP; p++) begin
      for (int b = 0; b < NB; b++) begin
        if (io.autofire_mask[b]) begin
          btn_o[NB*p+b] = btn_c[NB*p+b] & af_phase;
        end
      end
    end
  end
`else
  logic unused_af;
  assign unused_af = ^{io.autofire_mask, AUTOFIRE_DIV[0]};
  assign btn_o     = btn_c;
`endif

  logic [NP-1:0]    up_q;
  logic [NP-1:0]    dn_q;
  logic [NP-1:0]    lf_q;
  logic [NP-1:0]    rt_q;
  logic [NP-1:0]    st_q;
  logic [NP*NB-1:0] btn_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      up_q  <= '0;
      dn_q  <= '0;
      lf_q  <= '0;
      rt_q  <= '0;
      st_q  <= '0;
      btn_q <= '0;
    end else begin
      up_q  <= up_c;
      dn_q  <= dn_c;
      lf_q  <= lf_c;
      rt_q  <= rt_c;
      st_q  <= st_c;
      btn_q <= btn_o;
    end
  end

  assign io.p_up    = up_q;
  assign io.p_down  = dn_q;
  assign io.p_left  = lf_q;
  assign io.p_right = rt_q;
  assign io.p_start = st_q;
  assign io.p_btn   = btn_q;
  assign io.p_coin  = coin_w;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Scoreboard bench for arcade_input_mapper: stimulus queues expected
// levels / coin widths, a negedge monitor pops and compares them.
module tb_arcade_input_mapper;

  localparam int NP   = 2;
  localparam int NB   = 4;
  localparam int CMIN = 16;
  localparam int AFD  = 4;

  localparam logic [31:0] M_ALL = 32'h000F_FFFF;
  localparam logic [31:0] UP0   = 32'h1 << 0;
  localparam logic [31:0] UP1   = 32'h1 << 1;
  localparam logic [31:0] DN0   = 32'h1 << 2;
  localparam logic [31:0] LF0   = 32'h1 << 4;
  localparam logic [31:0] RT0   = 32'h1 << 6;
  localparam logic [31:0] BTN0  = 32'h1 << 8;
  localparam logic [31:0] BTN11 = 32'h1 << 13;
  localparam logic [31:0] ST0   = 32'h1 << 16;
  localparam logic [31:0] DIR0  = UP0 | DN0 | LF0 | RT0;

  logic clk_sys = 1'b0;
  logic reset_n;

  always #5 clk_sys = ~clk_sys;

  arcade_input_mapper_if #(
    .NUM_PLAYERS(NP),
    .NUM_BUTTONS(NB)
  ) bus ();

  arcade_input_mapper #(
    .NUM_PLAYERS    (NP),
    .NUM_BUTTONS    (NB),
    .COIN_MIN_CYCLES(CMIN),
    .AUTOFIRE_DIV   (AFD)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .io     (bus)
  );

  typedef struct {
    int          due;
    string       name;
    logic [31:0] mask;
    logic [31:0] exp;
  } chk_t;

  chk_t lvl_q[$];
  int   coin_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   run   = 0;
  logic tog;

  always @(posedge clk_sys) cyc <= cyc + 1;

  function automatic logic [31:0] snap();
    return {12'b0, bus.p_coin, bus.p_start, bus.p_btn,
            bus.p_right, bus.p_left, bus.p_down, bus.p_up};
  endfunction

  always @(negedge clk_sys) begin
    logic [31:0] s;
    s = snap();
    for (int i = lvl_q.size() - 1; i >= 0; i--) begin
      if (lvl_q[i].due <= cyc) begin
        tests++;
        if (lvl_q[i].due < cyc ||
            (s & lvl_q[i].mask) != lvl_q[i].exp) begin
          fails++;
          $display("FAIL %s: got %h want %h (cycle %0d)",
                   lvl_q[i].name, s & lvl_q[i].mask,
                   lvl_q[i].exp, cyc);
        end
        lvl_q.delete(i);
      end
    end
    if (bus.p_coin[0]) begin
      run++;
    end else if (run > 0) begin
      tests++;
      if (coin_q.size() == 0) begin
        fails++;
        $display("FAIL coin_width: got %0d want none", run);
      end else begin
        int w;
        w = coin_q.pop_front();
        if (run != w) begin
          fails++;
          $display("FAIL coin_width: got %0d want %0d", run, w);
        end
      end
      run = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic expect_at(input int lat, input string nm,
                           input logic [31:0] m,
                           input logic [31:0] e);
    chk_t c;
    c.due  = cyc + lat;
    c.name = nm;
    c.mask = m;
    c.exp  = e;
    lvl_q.push_back(c);
  endtask

  task automatic key(input logic p, input logic ext,
                     input logic [7:0] code);
    tog = ~tog;
    bus.ps2_key = {tog, p, ext, code};
  endtask

  initial begin
    reset_n           = 1'b1;
    tog               = 1'b1;
    bus.ps2_key       = {1'b1, 1'b1, 1'b0, 8'h75};
    bus.joystick      = '0;
    bus.rotate        = 1'b0;
    bus.merge_joy     = 1'b0;
    bus.autofire_mask = '0;
    #1 reset_n = 1'b0;
    tick(3);

    // 1: reset, stale ps2_key with toggle=1 must not decode
    expect_at(0, "reset_state", M_ALL, 32'h0);
    reset_n = 1'b1;
    expect_at(1, "prime_c1", M_ALL, 32'h0);
    expect_at(2, "prime_c2", M_ALL, 32'h0);
    expect_at(4, "prime_c4", M_ALL, 32'h0);
    tick(5);

    // 2: key up make/break, two-cycle latency
    key(1'b1, 1'b0, 8'h75);
    expect_at(1, "up_lat1", UP0, 32'h0);
    expect_at(2, "up_make", UP0, UP0);
    tick(4);
    key(1'b0, 1'b0, 8'h75);
    expect_at(1, "up_hold", UP0, UP0);
    expect_at(2, "up_break", UP0, 32'h0);
    tick(4);

    key(1'b1, 1'b1, 8'h6B);
    expect_at(2, "ext_left", DIR0, LF0);
    tick(4);
    key(1'b0, 1'b1, 8'h6B);
    expect_at(2, "ext_left_rel", DIR0, 32'h0);
    tick(4);

    key(1'b1, 1'b0, 8'h2D);
    expect_at(2, "p2_r_up", UP0 | UP1, UP1);
    tick(4);
    key(1'b0, 1'b0, 8'h2D);
    expect_at(2, "p2_r_rel", UP1, 32'h0);
    tick(4);

    key(1'b1, 1'b0, 8'h05);
    expect_at(2, "f1_start", ST0, ST0);
    tick(4);
    key(1'b0, 1'b0, 8'h05);
    expect_at(2, "f1_rel", ST0, 32'h0);
    tick(4);

    key(1'b1, 1'b0, 8'h29);
    expect_at(2, "space_btn0", BTN0, BTN0);
    tick(4);
    key(1'b1, 1'b0, 8'h44);
    expect_at(2, "unlisted", M_ALL, BTN0);
    tick(4);

    // 3: joystick, cleaning, rotate, merge
    bus.joystick[3:0] = 4'b1000;
    expect_at(1, "joy_up", UP0 | DN0, UP0);
    tick(2);
    bus.joystick[3:0] = 4'b1100;
    expect_at(1, "clean_ud", UP0 | DN0, 32'h0);
    tick(2);
    bus.joystick[3:0] = 4'b0011;
    expect_at(1, "clean_lr", LF0 | RT0, 32'h0);
    tick(2);
    bus.joystick[3:0] = 4'b0001;
    expect_at(1, "joy_right", LF0 | RT0, RT0);
    tick(2);
    bus.rotate        = 1'b1;
    bus.joystick[3:0] = 4'b0010;
    expect_at(1, "rot_left_up", DIR0, UP0);
    tick(2);
    bus.joystick[3:0] = 4'b1000;
    expect_at(1, "rot_up_right", DIR0, RT0);
    tick(2);
    bus.rotate   = 1'b0;
    bus.joystick = '0;
    expect_at(1, "joy_idle", DIR0, 32'h0);
    tick(2);
    bus.joystick[21] = 1'b1;
    expect_at(1, "p2_joy_btn1", BTN11, BTN11);
    tick(2);
    bus.joystick  = 32'h1 << 19;
    bus.merge_joy = 1'b1;
    expect_at(1, "merge_up", UP0 | UP1, UP0 | UP1);
    tick(2);
    bus.merge_joy = 1'b0;
    expect_at(1, "unmerge_up", UP0 | UP1, UP1);
    tick(2);
    bus.joystick = '0;
    tick(2);

    // 4: coin key, short and long press
    key(1'b1, 1'b0, 8'h2E);
    coin_q.push_back(CMIN);
    tick(3);
    key(1'b0, 1'b0, 8'h2E);
    tick(22);
    key(1'b1, 1'b0, 8'h2E);
    coin_q.push_back(40);
    tick(40);
    key(1'b0, 1'b0, 8'h2E);
    tick(10);

    // 5: reset mid pulse, joystick coin held across reset
    bus.joystick[9] = 1'b1;
    coin_q.push_back(4);
    tick(5);
    reset_n = 1'b0;
    expect_at(0, "reset_async", M_ALL, 32'h0);
    tick(2);
    reset_n = 1'b1;
    coin_q.push_back(CMIN);
    expect_at(3, "key_forgot", BTN0, 32'h0);
    tick(5);
    bus.joystick[9] = 1'b0;
    tick(20);

    // 6: fire held with autofire mask
    bus.autofire_mask = 4'b0001;
    bus.joystick[4]   = 1'b1;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    begin
      int hi;
      hi = 0;
      tick(2);
      for (int i = 0; i < 32; i++) begin
        if (bus.p_btn[0]) hi++;
        tick(1);
      end
      tests++;
      if (hi != 16) begin
        fails++;
        $display("FAIL autofire_duty: got %0d want 16", hi);
      end
    end
`else
    for (int i = 1; i <= 8; i++) begin
      expect_at(i, "fire_steady", BTN0, BTN0);
    end
    tick(10);
`endif
    bus.joystick = '0;
    tick(20);

    tests++;
    if (lvl_q.size() != 0 || coin_q.size() != 0) begin
      fails++;
      $display("FAIL pending: got %0d/%0d want 0/0",
               lvl_q.size(), coin_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
